// File: rtl/aoi22_arc_exerciser_pkg.sv
// Shared types, constants and the AOI22 reference function for the arc exerciser.
// ZN = ~((A1&A2)|(B1&B2)).
package aoi22_arc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SET  = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } phase_t;

  localparam int NUM_ARCS   = 12;
  localparam int NUM_CHECKS = 36;

  function automatic logic aoi22_ref(input logic a1, input logic a2,
                                     input logic b1, input logic b2);
    return ~((a1 & a2) | (b1 & b2));
  endfunction

endpackage

// File: rtl/aoi22_arc_exerciser_if.sv
// Pin drives, ZN return and run status between the exerciser and its host/DUT side.
// The exerciser uses the master modport.
interface aoi22_arc_exerciser_if;
  logic       START;
  logic       ZN_I;
  logic       A1_O;
  logic       A2_O;
  logic       B1_O;
  logic       B2_O;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [5:0] ERR_CNT;
  logic       ERR_VLD;
  logic [3:0] FIRST_ERR_ARC;
  logic [1:0] FIRST_ERR_PH;

  modport master (
    input  START, ZN_I,
    output A1_O, A2_O, B1_O, B2_O, BUSY, DONE, PASS,
           ERR_CNT, ERR_VLD, FIRST_ERR_ARC, FIRST_ERR_PH
  );

  modport slave (
    output START, ZN_I,
    input  A1_O, A2_O, B1_O, B2_O, BUSY, DONE, PASS,
           ERR_CNT, ERR_VLD, FIRST_ERR_ARC, FIRST_ERR_PH
  );
endinterface

// File: rtl/aoi22_arc_vec.sv
// Combinational decode of (arc, phase) into the pin vector {A1,A2,B1,B2} and expected ZN.
// Switching pin = arc/3, side condition = arc%3 selects {00,01,10} on the opposite pair.
module aoi22_arc_vec
  import aoi22_arc_pkg::*;
(
  input  logic [3:0] arc,
  input  phase_t     phase,
  output logic [3:0] pins,
  output logic       exp_zn
);

  logic [1:0] sw;
  logic [1:0] side;
  logic       sw_val;

  always_comb begin
    sw     = 2'd0;
    side   = 2'b00;
    sw_val = (phase == RISE);
    pins   = 4'b0000;

    case (arc)
      4'd0, 4'd1, 4'd2:  sw = 2'd0;
      4'd3, 4'd4, 4'd5:  sw = 2'd1;
      4'd6, 4'd7, 4'd8:  sw = 2'd2;
      default:           sw = 2'd3;
    endcase

    case (arc)
      4'd0, 4'd3, 4'd6, 4'd9:  side = 2'b00;
      4'd1, 4'd4, 4'd7, 4'd10: side = 2'b01;
      default:                 side = 2'b10;
    endcase

    // Partner pin of the switching pin is held at 1 so the arc is sensitized.
    case (sw)
      2'd0:    pins = {sw_val, 1'b1, side};
      2'd1:    pins = {1'b1, sw_val, side};
      2'd2:    pins = {side, sw_val, 1'b1};
      default: pins = {side, 1'b1, sw_val};
    endcase

    exp_zn = aoi22_ref(pins[3], pins[2], pins[1], pins[0]);
  end

endmodule

// File: rtl/aoi22_arc_exerciser.sv
// Steps the AOI22 pins through all 12 sensitized arcs (SET/RISE/FALL), samples ZN
// after SETTLE cycles per vector and records mismatch count and the first failing arc.
//
// state  | meaning
// IDLE   | pins 0, waiting for START
// RUN    | driving (arc, phase) vectors, sampling ZN at end of each settle window
// FINISH | one-cycle DONE pulse, results final
module aoi22_arc_exerciser
  import aoi22_arc_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                   CK,
  input  logic                   RST,
  aoi22_arc_exerciser_if.master  bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] arc_q;
  phase_t     ph_q;
  logic [3:0] settle_cnt;
  logic [3:0] pins_q;
  logic       exp_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [5:0] err_cnt_q;
  logic       err_vld_q;
  logic [3:0] first_arc_q;
  logic [1:0] first_ph_q;

  logic [3:0] arc_nx;
  phase_t     ph_nx;
  logic       last;
  logic [3:0] dec_arc;
  phase_t     dec_ph;
  logic [3:0] dec_pins;
  logic       dec_exp;
  logic       mismatch;
  logic [5:0] err_cnt_nx;

  always_comb begin
    arc_nx = arc_q;
    ph_nx  = SET;
    case (ph_q)
      SET:     ph_nx = RISE;
      RISE:    ph_nx = FALL;
      default: begin
        ph_nx  = SET;
        arc_nx = arc_q + 4'd1;
      end
    endcase
    last = (arc_q == 4'(NUM_ARCS - 1)) && (ph_q == FALL);

    // In IDLE the decoder presents the first vector so it can be loaded on START.
    dec_arc = (state == RUN) ? arc_nx : 4'd0;
    dec_ph  = (state == RUN) ? ph_nx : SET;

    mismatch   = (state == RUN) && (settle_cnt == 4'd0) && (bus.ZN_I != exp_q);
    err_cnt_nx = err_cnt_q + (mismatch ? 6'd1 : 6'd0);
  end

  aoi22_arc_vec u_vec (
    .arc    (dec_arc),
    .phase  (dec_ph),
    .pins   (dec_pins),
    .exp_zn (dec_exp)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      state       <= IDLE;
      arc_q       <= 4'd0;
      ph_q        <= SET;
      settle_cnt  <= 4'd0;
      pins_q      <= 4'b0000;
      exp_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 6'd0;
      err_vld_q   <= 1'b0;
      first_arc_q <= 4'd0;
      first_ph_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            arc_q       <= 4'd0;
            ph_q        <= SET;
            settle_cnt  <= SETTLE_LD;
            pins_q      <= dec_pins;
            exp_q       <= dec_exp;
            pass_q      <= 1'b0;
            err_cnt_q   <= 6'd0;
            err_vld_q   <= 1'b0;
            first_arc_q <= 4'd0;
            first_ph_q  <= 2'd0;
          end
        end
        RUN: begin
          if (settle_cnt == 4'd0) begin
            err_cnt_q <= err_cnt_nx;
            if (mismatch && !err_vld_q) begin
              err_vld_q   <= 1'b1;
              first_arc_q <= arc_q;
              first_ph_q  <= ph_q;
            end
            if (last) begin
              state  <= FINISH;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pins_q <= 4'b0000;
              pass_q <= (err_cnt_nx == 6'd0);
            end else begin
              arc_q      <= arc_nx;
              ph_q       <= ph_nx;
              settle_cnt <= SETTLE_LD;
              pins_q     <= dec_pins;
              exp_q      <= dec_exp;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A1_O          = pins_q[3];
  assign bus.A2_O          = pins_q[2];
  assign bus.B1_O          = pins_q[1];
  assign bus.B2_O          = pins_q[0];
  assign bus.BUSY          = busy_q;
  assign bus.DONE          = done_q;
  assign bus.PASS          = pass_q;
  assign bus.ERR_CNT       = err_cnt_q;
  assign bus.ERR_VLD       = err_vld_q;
  assign bus.FIRST_ERR_ARC = first_arc_q;
  assign bus.FIRST_ERR_PH  = first_ph_q;

endmodule

// File: tb/tb_aoi22_arc_exerciser.sv
// Scoreboard bench for aoi22_arc_exerciser: stimulus pushes expected run results,
// a monitor checks every pin vector during BUSY and pops results on each DONE.
module tb_aoi22_arc_exerciser;

  localparam int S       = 2;
  localparam int RUN_LEN = 36 * S;

  typedef struct {
    int pass;
    int cnt;
    int vld;
    int arc;
    int ph;
  } res_t;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] zn_mode = 2'd0;
  logic [3:0] pv;
  logic       ideal;

  res_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   bcnt  = 0;

  // Hand-computed RISE vectors {A1,A2,B1,B2} per arc and the switching-pin mask.
  logic [3:0] rise_tab [12] = '{4'b1100, 4'b1101, 4'b1110,
                                4'b1100, 4'b1101, 4'b1110,
                                4'b0011, 4'b0111, 4'b1011,
                                4'b0011, 4'b0111, 4'b1011};
  logic [3:0] mask_tab [12] = '{4'b1000, 4'b1000, 4'b1000,
                                4'b0100, 4'b0100, 4'b0100,
                                4'b0010, 4'b0010, 4'b0010,
                                4'b0001, 4'b0001, 4'b0001};

  always #5 CK = ~CK;

  aoi22_arc_exerciser_if bus ();

  aoi22_arc_exerciser #(.SETTLE(S)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus.master)
  );

  assign pv    = {bus.A1_O, bus.A2_O, bus.B1_O, bus.B2_O};
  assign ideal = ~((pv[3] & pv[2]) | (pv[1] & pv[0]));
  // Modes: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 ideal but inverted on vector 0111.
  assign bus.ZN_I = (zn_mode == 2'd1) ? 1'b1 :
                    (zn_mode == 2'd2) ? 1'b0 :
                    (ideal ^ ((zn_mode == 2'd3) && (pv == 4'b0111)));

  function automatic logic [3:0] exp_pins(input int n);
    int k;
    int p;
    k = n / 3;
    p = n % 3;
    return (p == 1) ? rise_tab[k] : (rise_tab[k] & ~mask_tab[k]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    res_t r;
    forever begin
      @(posedge CK);
      #1;
      if (RST) bcnt = 0;
      if (bus.BUSY) begin
        if (bcnt < RUN_LEN) check("run_pins", int'(pv), int'(exp_pins(bcnt / S)));
        else                check("run_overlong", bcnt, RUN_LEN - 1);
        bcnt++;
      end else begin
        check("idle_pins", int'(pv), 0);
        if (bus.DONE) begin
          check("run_len", bcnt, RUN_LEN);
          bcnt = 0;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            r = sb_q.pop_front();
            check("pass",      int'(bus.PASS),          r.pass);
            check("err_cnt",   int'(bus.ERR_CNT),       r.cnt);
            check("err_vld",   int'(bus.ERR_VLD),       r.vld);
            check("first_arc", int'(bus.FIRST_ERR_ARC), r.arc);
            check("first_ph",  int'(bus.FIRST_ERR_PH),  r.ph);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge CK);
    bus.START = 1'b1;
    @(negedge CK);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.DONE && n < 4 * RUN_LEN) begin
      @(negedge CK);
      n++;
    end
    check(name, int'(bus.DONE), 1);
    @(negedge CK);
  endtask

  task automatic run(input logic [1:0] mode, input res_t e, input string name);
    zn_mode = mode;
    sb_q.push_back(e);
    pulse_start();
    check("busy_after_start", int'(bus.BUSY), 1);
    check("err_cleared", int'(bus.ERR_CNT), 0);
    wait_done(name);
  endtask

  initial begin
    res_t e;
    int   gap;
    bus.START = 1'b0;
    repeat (3) @(negedge CK);
    check("rst_busy",  int'(bus.BUSY), 0);
    check("rst_done",  int'(bus.DONE), 0);
    check("rst_pass",  int'(bus.PASS), 0);
    check("rst_cnt",   int'(bus.ERR_CNT), 0);
    check("rst_vld",   int'(bus.ERR_VLD), 0);
    check("rst_arc",   int'(bus.FIRST_ERR_ARC), 0);
    check("rst_ph",    int'(bus.FIRST_ERR_PH), 0);
    check("rst_pins",  int'(pv), 0);
    RST = 1'b0;
    @(negedge CK);

    // Ideal run with a directed look at arc 7 RISE (check index 22).
    zn_mode = 2'd0;
    e = '{pass: 1, cnt: 0, vld: 0, arc: 0, ph: 0};
    sb_q.push_back(e);
    pulse_start();
    repeat (22 * S) @(negedge CK);
    for (int i = 0; i < S; i++) begin
      check("arc7_rise_pins", int'(pv), 4'b0111);
      check("arc7_rise_zn", int'(bus.ZN_I), 0);
      @(negedge CK);
    end
    wait_done("ideal_done");

    e = '{pass: 0, cnt: 12, vld: 1, arc: 0, ph: 1};
    run(2'd1, e, "stuck1_done");
    e = '{pass: 0, cnt: 24, vld: 1, arc: 0, ph: 0};
    run(2'd2, e, "stuck0_done");
    e = '{pass: 0, cnt: 2, vld: 1, arc: 7, ph: 1};
    run(2'd3, e, "arc7_fault_done");

    // START re-pulsed mid-run must be ignored.
    zn_mode = 2'd0;
    e = '{pass: 1, cnt: 0, vld: 0, arc: 0, ph: 0};
    sb_q.push_back(e);
    pulse_start();
    repeat (30) @(negedge CK);
    bus.START = 1'b1;
    @(negedge CK);
    bus.START = 1'b0;
    wait_done("midstart_done");
    repeat (3) @(negedge CK);
    check("midstart_no_rerun", int'(bus.BUSY), 0);

    // START held high: two back-to-back runs, DONE pulses 74 cycles apart.
    sb_q.push_back(e);
    sb_q.push_back(e);
    @(negedge CK);
    bus.START = 1'b1;
    wait_done("held_done1");
    gap = 1;
    while (!bus.DONE && gap < 4 * RUN_LEN) begin
      @(negedge CK);
      gap++;
    end
    bus.START = 1'b0;
    check("held_gap", gap, RUN_LEN + 2);
    repeat (3) @(negedge CK);
    check("held_stopped", int'(bus.BUSY), 0);

    // Reset mid-run discards the run.
    sb_q.push_back(e);
    pulse_start();
    repeat (19) @(negedge CK);
    RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_pins", int'(pv), 0);
    check("abort_done", int'(bus.DONE), 0);
    check("abort_cnt",  int'(bus.ERR_CNT), 0);
    void'(sb_q.pop_back());
    repeat (RUN_LEN + 5) @(negedge CK);

    sb_q.push_back(e);
    pulse_start();
    wait_done("fresh_done");
    repeat (4) @(negedge CK);
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
